// File: rtl/matrix_merge_64.sv
// -----------------------------------------------------------------------------
// matrix_merge_64_top
//
// Purpose:
//   Rebuilds one 64x64 matrix from sixteen 16x16 tiles. Tiles come from the
//   PE16 array in any order, and each tile carries its slot index. This block
//   undoes the 64x64 -> 16-tile selector that sits in front of the array.
//   When every slot has been filled, the assembled matrix is presented and
//   finish stays high until the consumer answers with mat_ack.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   tile_valid in   1      tile_idx / tile_data are valid
//   tile_ready out  1      a tile can be accepted this cycle
//   tile_idx   in   4      slot k = tr*GRID + tc
//   tile_data  in   4096   tile element (i,j) at bits [(i*16+j)*16 +: 16]
//   Matrix     out  65536  matrix element (r,c) at bits [(r*64+c)*16 +: 16]
//   finish     out  1      Matrix is complete and stable; held until mat_ack
//   mat_ack    in   1      consumer has taken Matrix; re-arms the block
//   tile_cnt   out  5      number of distinct slots filled (0..16)
//   dup_err    out  1      present only when MERGE_DUP_ERR_EN is defined
//
// Configuration macro:
//   MERGE_DUP_ERR_EN - when defined, a second tile for a slot that is already
//   filled is dropped (the first data wins) and the sticky dup_err output is
//   set. dup_err is cleared only by rst. When the macro is undefined, a
//   repeated slot simply overwrites the earlier data and no dup_err port
//   exists.
// -----------------------------------------------------------------------------
module matrix_merge_64_top #(
  parameter int DATA_W   = 16,
  parameter int TILE_DIM = 16,
  parameter int GRID     = 4
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              tile_valid,
  output logic                                              tile_ready,
  input  logic [3:0]                                        tile_idx,
  input  logic [TILE_DIM*TILE_DIM*DATA_W-1:0]               tile_data,
  output logic [GRID*TILE_DIM*GRID*TILE_DIM*DATA_W-1:0]     Matrix,
  output logic                                              finish,
  input  logic                                              mat_ack,
`ifdef MERGE_DUP_ERR_EN
  output logic                                              dup_err,
`endif
  output logic [4:0]                                        tile_cnt
);

  localparam int MAT_DIM   = GRID * TILE_DIM;
  localparam int NUM_TILES = GRID * GRID;
  localparam int ROW_BITS  = TILE_DIM * DATA_W;
  localparam int GRID_W    = $clog2(GRID);

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

  state_t               state;
  logic [NUM_TILES-1:0] mask;

  logic [GRID_W-1:0]    slot_row;
  logic [GRID_W-1:0]    slot_col;
  logic [NUM_TILES-1:0] slot_onehot;
  logic [NUM_TILES-1:0] mask_next;
  logic                 slot_taken;
  logic                 accept;
  logic                 write_en;

  // The slot index is split into its tile row (upper bits) and tile column
  // (lower bits). Those two values pick the 16x16 window of the matrix that
  // this tile covers.
  assign slot_row = tile_idx[2*GRID_W-1:GRID_W];
  assign slot_col = tile_idx[GRID_W-1:0];

  // The block is ready in COLLECT and never ready while reset is asserted.
  // The ready signal never looks at tile_valid, so the source is free to wait
  // for it before raising valid.
  assign tile_ready = (state == COLLECT) & ~rst;
  assign accept     = tile_valid & tile_ready;

  // Occupancy bookkeeping. slot_taken shows a slot being filled a second
  // time within a frame. mask_next is the occupancy after this accept and is
  // used to detect completion on the same edge.
  assign slot_onehot = NUM_TILES'(1) << tile_idx;
  assign slot_taken  = |(mask & slot_onehot);
  assign mask_next   = mask | slot_onehot;

  // Decide whether the tile data lands in Matrix. With duplicate checking
  // enabled, the first tile for a slot is kept and later ones are dropped.
  // Without it, the newest tile for a slot overwrites the older one.
`ifdef MERGE_DUP_ERR_EN
  assign write_en = accept & ~slot_taken;
`else
  assign write_en = accept;
`endif

  // Main control and datapath register.
  // Reset returns to an empty COLLECT frame and also zeroes the matrix.
  // In COLLECT, each accept copies the tile into its window one tile row at
  // a time. A tile row is TILE_DIM contiguous elements, and in the matrix it
  // is also contiguous, so each row is a single part-select. The edge that
  // fills the last empty slot moves the FSM to DONE and raises finish. That
  // edge has also written the final tile, so finish and valid data appear
  // together.
  // In DONE, nothing is accepted and mat_ack re-arms the block. The matrix
  // contents are kept, and the next frame overwrites them tile by tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= COLLECT;
      mask     <= '0;
      tile_cnt <= '0;
      finish   <= 1'b0;
      Matrix   <= '0;
`ifdef MERGE_DUP_ERR_EN
      dup_err  <= 1'b0;
`endif
    end else begin
      case (state)
        COLLECT: begin
          if (write_en) begin
            for (int i = 0; i < TILE_DIM; i++) begin
              Matrix[((int'(slot_row) * TILE_DIM + i) * MAT_DIM
                      + int'(slot_col) * TILE_DIM) * DATA_W +: ROW_BITS]
                <= tile_data[i*ROW_BITS +: ROW_BITS];
            end
          end
          if (accept) begin
            mask <= mask_next;
            if (!slot_taken) begin
              tile_cnt <= tile_cnt + 5'd1;
            end
`ifdef MERGE_DUP_ERR_EN
            if (slot_taken) begin
              dup_err <= 1'b1;
            end
`endif
            if (&mask_next) begin
              state  <= DONE;
              finish <= 1'b1;
            end
          end
        end
        DONE: begin
          if (mat_ack) begin
            state    <= COLLECT;
            finish   <= 1'b0;
            mask     <= '0;
            tile_cnt <= '0;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_merge_64_top.sv
// -----------------------------------------------------------------------------
// tb_matrix_merge_64_top
//
// Bench for matrix_merge_64_top. The reference is a plain 64x64 element
// array together with a set of filled slots. On every negative edge the DUT
// outputs are compared against that reference. Directed sequences exercise
// in-order fill, shuffled fill with gaps, duplicates, DONE backpressure,
// reset mid-frame and mat_ack during collection. Literal expectations anchor
// the reference to hand-computed values.
// -----------------------------------------------------------------------------
module tb_matrix_merge_64_top;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          tile_valid = 1'b0;
  logic          tile_ready;
  logic [3:0]    tile_idx   = 4'd0;
  logic [4095:0] tile_data  = '0;
  logic [65535:0] Matrix;
  logic          finish;
  logic          mat_ack    = 1'b0;
  logic [4:0]    tile_cnt;
`ifdef MERGE_DUP_ERR_EN
  logic          dup_err;
`endif

  int checks = 0;
  int errors = 0;

  matrix_merge_64_top dut (
    .clk        (clk),
    .rst        (rst),
    .tile_valid (tile_valid),
    .tile_ready (tile_ready),
    .tile_idx   (tile_idx),
    .tile_data  (tile_data),
    .Matrix     (Matrix),
    .finish     (finish),
    .mat_ack    (mat_ack),
`ifdef MERGE_DUP_ERR_EN
    .dup_err    (dup_err),
`endif
    .tile_cnt   (tile_cnt)
  );

  always #5 clk = ~clk;

  // Reference state. It holds the matrix as a 2-D array of elements, a flag
  // per slot, a done flag and a sticky duplicate flag.
  logic [15:0] m_mat [0:63][0:63];
  bit          m_filled [0:15];
  bit          m_done;
  bit          m_dup;

  function automatic int count_filled();
    int n = 0;
    for (int k = 0; k < 16; k++) n += int'(m_filled[k]);
    return n;
  endfunction

  function automatic logic [4095:0] make_tile(input int k, input logic [15:0] xorv);
    logic [4095:0] t;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        t[(i*16+j)*16 +: 16] = 16'(k*256 + i*16 + j) ^ xorv;
    return t;
  endfunction

  function automatic logic [15:0] dut_elem(input int r, input int c);
    return Matrix[(r*64+c)*16 +: 16];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Advance the reference by one clock edge, applying the handshake rules.
  task automatic model_step();
    bit first_wins;
`ifdef MERGE_DUP_ERR_EN
    first_wins = 1'b1;
`else
    first_wins = 1'b0;
`endif
    if (rst) begin
      for (int r = 0; r < 64; r++)
        for (int c = 0; c < 64; c++) m_mat[r][c] = 16'd0;
      for (int k = 0; k < 16; k++) m_filled[k] = 1'b0;
      m_done = 1'b0;
      m_dup  = 1'b0;
    end else if (m_done) begin
      if (mat_ack) begin
        m_done = 1'b0;
        for (int k = 0; k < 16; k++) m_filled[k] = 1'b0;
      end
    end else if (tile_valid) begin
      int k;
      k = int'(tile_idx);
      if (m_filled[k] && first_wins) begin
        m_dup = 1'b1;
      end else begin
        for (int i = 0; i < 16; i++)
          for (int j = 0; j < 16; j++)
            m_mat[(k/4)*16+i][(k%4)*16+j] = tile_data[(i*16+j)*16 +: 16];
      end
      m_filled[k] = 1'b1;
      if (count_filled() == 16) m_done = 1'b1;
    end
  endtask

  // Compare every DUT output against the reference. For Matrix, only the
  // first differing element is reported so the line stays short.
  task automatic compare_step();
    logic [65535:0] exp_mat;
    int bad_r;
    int bad_c;
    checkOutput("cmp_tile_ready", {31'd0, tile_ready}, {31'd0, (!m_done && !rst)});
    checkOutput("cmp_finish", {31'd0, finish}, {31'd0, m_done});
    checkOutput("cmp_tile_cnt", {27'd0, tile_cnt}, count_filled());
`ifdef MERGE_DUP_ERR_EN
    checkOutput("cmp_dup_err", {31'd0, dup_err}, {31'd0, m_dup});
`endif
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) exp_mat[(r*64+c)*16 +: 16] = m_mat[r][c];
    checks++;
    if (Matrix !== exp_mat) begin
      bad_r = -1;
      bad_c = -1;
      for (int r = 0; r < 64; r++)
        for (int c = 0; c < 64; c++)
          if (bad_r < 0 && dut_elem(r, c) !== m_mat[r][c]) begin
            bad_r = r;
            bad_c = c;
          end
      errors++;
      if (bad_r >= 0)
        $display("[TB] FAIL cmp_matrix elem(%0d,%0d) actual=%0h expected=%0h",
                 bad_r, bad_c, dut_elem(bad_r, bad_c), m_mat[bad_r][bad_c]);
      else
        $display("[TB] FAIL cmp_matrix actual has X/Z bits expected=known");
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    compare_step();
  end

  // Present one tile and hold it until the DUT takes it. The task is called
  // at posedge+1 and returns at posedge+1 just after the accepting edge.
  task automatic applyStimulus(input int k, input logic [15:0] xorv);
    int waited;
    tile_valid = 1'b1;
    tile_idx   = k[3:0];
    tile_data  = make_tile(k, xorv);
    waited     = 0;
    forever begin
      @(negedge clk);
      if (tile_ready) break;
      waited++;
      if (waited > 50) begin
        checkOutput("accept_timeout", 32'd0, 32'd1);
        tile_valid = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic next_cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    mat_ack = 1'b1;
    next_cycle(1);
    mat_ack = 1'b0;
  endtask

  int order [16] = '{15, 3, 8, 1, 10, 6, 13, 4, 11, 2, 14, 7, 9, 5, 12, 0};

  initial begin
    next_cycle(3);
    rst = 1'b0;
    next_cycle(1);

    // In-order, back-to-back fill.
    for (int k = 0; k < 16; k++) applyStimulus(k, 16'h0000);
    tile_valid = 1'b0;
    @(negedge clk);
    checkOutput("t1_finish", {31'd0, finish}, 32'd1);
    checkOutput("t1_tile_cnt", {27'd0, tile_cnt}, 32'd16);
    checkOutput("t1_elem_17_33", {16'd0, dut_elem(17, 33)}, 32'h0611);
    checkOutput("t1_elem_63_63", {16'd0, dut_elem(63, 63)}, 32'h0FFF);
    checkOutput("t1_elem_5_60", {16'd0, dut_elem(5, 60)}, 32'h035C);
    checkOutput("t1_elem_0_0", {16'd0, dut_elem(0, 0)}, 32'h0000);
    checkOutput("model_pin_17_33", {16'd0, m_mat[17][33]}, 32'h0611);

    // Hold a tile on the input while DONE, then acknowledge.
    next_cycle(1);
    tile_valid = 1'b1;
    tile_idx   = 4'd0;
    tile_data  = make_tile(0, 16'h5555);
    next_cycle(3);
    @(negedge clk);
    checkOutput("t4_ready_in_done", {31'd0, tile_ready}, 32'd0);
    checkOutput("t4_cnt_in_done", {27'd0, tile_cnt}, 32'd16);
    next_cycle(1);
    mat_ack = 1'b1;
    @(negedge clk);
    checkOutput("t4_ready_ack_cycle", {31'd0, tile_ready}, 32'd0);
    next_cycle(1);
    mat_ack = 1'b0;
    @(negedge clk);
    checkOutput("t4_ready_after_ack", {31'd0, tile_ready}, 32'd1);
    checkOutput("t4_finish_after_ack", {31'd0, finish}, 32'd0);
    checkOutput("t4_cnt_after_ack", {27'd0, tile_cnt}, 32'd0);
    next_cycle(1);
    tile_valid = 1'b0;
    @(negedge clk);
    checkOutput("t4_cnt_held_tile", {27'd0, tile_cnt}, 32'd1);
    checkOutput("t4_elem_0_0", {16'd0, dut_elem(0, 0)}, 32'h5555);

    // mat_ack during COLLECT must not change anything.
    next_cycle(1);
    pulse_ack();
    @(negedge clk);
    checkOutput("t6_cnt_kept", {27'd0, tile_cnt}, 32'd1);
    checkOutput("t6_ready_kept", {31'd0, tile_ready}, 32'd1);

    // Reset in the middle of a frame, then run a full frame of negative values.
    next_cycle(1);
    for (int k = 1; k < 7; k++) applyStimulus(k, 16'h0F0F);
    tile_valid = 1'b0;
    @(negedge clk);
    checkOutput("t5_cnt_before_rst", {27'd0, tile_cnt}, 32'd7);
    next_cycle(1);
    rst = 1'b1;
    next_cycle(1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_matrix_zero", {31'd0, |Matrix}, 32'd0);
    checkOutput("t5_cnt_zero", {27'd0, tile_cnt}, 32'd0);
    checkOutput("t5_finish_zero", {31'd0, finish}, 32'd0);
    next_cycle(1);
    for (int k = 0; k < 16; k++) applyStimulus(k, 16'h8000);
    tile_valid = 1'b0;
    @(negedge clk);
    checkOutput("t5_finish", {31'd0, finish}, 32'd1);
    checkOutput("t5_elem_0_0", {16'd0, dut_elem(0, 0)}, 32'h8000);
    checkOutput("t5_elem_63_63", {16'd0, dut_elem(63, 63)}, 32'h8FFF);
    next_cycle(1);
    pulse_ack();

    // Shuffled order with gaps in tile_valid.
    for (int n = 0; n < 16; n++) begin
      applyStimulus(order[n], 16'h0000);
      tile_valid = 1'b0;
      @(negedge clk);
      checkOutput("t2_tile_cnt", {27'd0, tile_cnt}, n + 1);
      checkOutput("t2_finish", {31'd0, finish}, (n == 15) ? 32'd1 : 32'd0);
      next_cycle((n % 3) + 1);
    end
    checkOutput("t2_elem_17_33", {16'd0, dut_elem(17, 33)}, 32'h0611);
    checkOutput("t2_elem_63_63", {16'd0, dut_elem(63, 63)}, 32'h0FFF);
    checkOutput("t2_elem_0_0", {16'd0, dut_elem(0, 0)}, 32'h0000);
    pulse_ack();

    // Duplicate slot 5 (A then B), then the remaining fifteen tiles.
    applyStimulus(5, 16'h1111);
    applyStimulus(5, 16'h2222);
    tile_valid = 1'b0;
    @(negedge clk);
    checkOutput("t3_cnt_after_dup", {27'd0, tile_cnt}, 32'd1);
    next_cycle(1);
    for (int k = 0; k < 16; k++)
      if (k != 5) applyStimulus(k, 16'h0000);
    tile_valid = 1'b0;
    @(negedge clk);
    checkOutput("t3_finish", {31'd0, finish}, 32'd1);
    checkOutput("t3_tile_cnt", {27'd0, tile_cnt}, 32'd16);
`ifdef MERGE_DUP_ERR_EN
    checkOutput("t3_slot5_first_wins", {16'd0, dut_elem(16, 16)}, 32'h1411);
    checkOutput("t3_dup_err", {31'd0, dup_err}, 32'd1);
`else
    checkOutput("t3_slot5_last_wins", {16'd0, dut_elem(16, 16)}, 32'h2722);
`endif
    next_cycle(1);
    pulse_ack();
    @(negedge clk);
`ifdef MERGE_DUP_ERR_EN
    checkOutput("t3_dup_err_after_ack", {31'd0, dup_err}, 32'd1);
`endif
    checkOutput("t3_cnt_after_ack", {27'd0, tile_cnt}, 32'd0);
    next_cycle(1);
    rst = 1'b1;
    next_cycle(1);
    rst = 1'b0;
    @(negedge clk);
`ifdef MERGE_DUP_ERR_EN
    checkOutput("t3_dup_err_after_rst", {31'd0, dup_err}, 32'd0);
`endif
    checkOutput("final_ready", {31'd0, tile_ready}, 32'd1);
    next_cycle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
